mem_port_arbiter: RTL and testbench

- Shares one single-port `memory` instance between the fetch stage (instruction reads) and the MEM stage (data reads and writes).
- Issues at most one access per cycle to the memory and routes each read response back to its owner. The memory returns read data one cycle after the address.
- Drives per-requester grant signals. The pipeline stalls any stage whose request is pending without a grant.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_if.sv | 30 +++
 rtl/mem_port_arb_perf.sv | 24 ++
 rtl/mem_port_arbiter.sv | 59 +++++
 tb/tb_mem_port_arbiter.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared widths, read-FSM state encoding and access owner codes
package mem_port_arbiter_pkg;
  localparam int ARB_ISIZE = 32;
  localparam int ARB_DSIZE = 32;
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_RD_IF = 2'd1,
    ARB_RD_DM = 2'd2
  } arb_state_e;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the shared memory port
interface mem_port_arbiter_if import mem_port_arbiter_pkg::*; #(
  parameter int ISIZE = ARB_ISIZE,
  parameter int DSIZE = ARB_DSIZE
);
  logic             if_req;
  logic [ISIZE-1:0] if_addr;
  logic             if_gnt;
  logic             if_rvalid;
  logic [DSIZE-1:0] if_rdata;
  logic             dm_req;
  logic             dm_we;
  logic [DSIZE-1:0] dm_addr;
  logic [DSIZE-1:0] dm_wdata;
  logic             dm_gnt;
  logic             dm_rvalid;
  logic [DSIZE-1:0] dm_rdata;
  logic             mem_wen;
  logic [DSIZE-1:0] mem_addr;
  logic [DSIZE-1:0] mem_wdata;
  logic [DSIZE-1:0] mem_rdata;
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, mem_wen, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arb_perf.sv
// mem_port_arb_perf: wrapping grant and conflict event counters
module mem_port_arb_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_gnt_i,
  input  logic        dm_gnt_i,
  input  logic        conflict_i,
  output logic [31:0] perf_if_grants_o,
  output logic [31:0] perf_dm_grants_o,
  output logic [31:0] perf_conflicts_o
);
  // count one event per cycle, wrapping naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_grants_o <= '0;
      perf_dm_grants_o <= '0;
      perf_conflicts_o <= '0;
    end else begin
      perf_if_grants_o <= perf_if_grants_o + 32'(if_gnt_i);
      perf_dm_grants_o <= perf_dm_grants_o + 32'(dm_gnt_i);
      perf_conflicts_o <= perf_conflicts_o + 32'(conflict_i);
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and MEM stage; MEM_PORT_ARB_PERF_EN adds perf counters
module mem_port_arbiter import mem_port_arbiter_pkg::*; #(
  parameter int ISIZE    = ARB_ISIZE,
  parameter int DSIZE    = ARB_DSIZE,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef MEM_PORT_ARB_PERF_EN
  output logic [31:0] perf_if_grants,
  output logic [31:0] perf_dm_grants,
  output logic [31:0] perf_conflicts,
`endif
  mem_port_arbiter_if.slave bus
);
  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);
  logic [3:0] starve_cnt_q, starve_cnt_d;
  arb_state_e state_q;
  logic       if_gnt, dm_gnt;
  owner_e     owner;
  // data side wins contention unless fetch has been denied MAX_WAIT cycles in a row
  always_comb begin
    if_gnt       = !rst && bus.if_req && (!bus.dm_req || starve_cnt_q == MAX_CNT);
    dm_gnt       = !rst && bus.dm_req && !if_gnt;
    owner        = if_gnt ? OWN_IF : dm_gnt ? OWN_DM : OWN_NONE;
    starve_cnt_d = if_gnt ? '0 : (bus.if_req && starve_cnt_q != MAX_CNT) ? starve_cnt_q + 4'd1 : starve_cnt_q;
  end
  // read-in-flight tracker and starvation counter; a granted write leaves nothing in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= if_gnt ? ARB_RD_IF : (dm_gnt && !bus.dm_we) ? ARB_RD_DM : ARB_IDLE;
      starve_cnt_q <= starve_cnt_d;
    end
  end
  assign bus.if_gnt    = if_gnt;
  assign bus.dm_gnt    = dm_gnt;
  assign bus.mem_wen   = owner == OWN_DM && bus.dm_we;
  assign bus.mem_addr  = owner == OWN_IF ? DSIZE'(bus.if_addr) : owner == OWN_DM ? bus.dm_addr : '0;
  assign bus.mem_wdata = owner == OWN_DM ? bus.dm_wdata : '0;
  assign bus.if_rvalid = state_q == ARB_RD_IF && !rst;
  assign bus.dm_rvalid = state_q == ARB_RD_DM && !rst;
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
  assign bus.dm_rdata  = bus.dm_rvalid ? bus.mem_rdata : '0;
`ifdef MEM_PORT_ARB_PERF_EN
  mem_port_arb_perf u_perf (
    .clk              (clk),
    .rst              (rst),
    .if_gnt_i         (if_gnt),
    .dm_gnt_i         (dm_gnt),
    .conflict_i       (bus.if_req && bus.dm_req),
    .perf_if_grants_o (perf_if_grants),
    .perf_dm_grants_o (perf_dm_grants),
    .perf_conflicts_o (perf_conflicts)
  );
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random stimulus with a queue scoreboard for read responses
module tb_mem_port_arbiter;
  localparam int MAX_WAIT = 4;
  typedef struct {
    logic [31:0] d;
    int          due;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic run = 1'b0;
  mem_port_arbiter_if bus ();
`ifdef MEM_PORT_ARB_PERF_EN
  logic [31:0] perf_if_grants, perf_dm_grants, perf_conflicts;
`endif
  mem_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
`ifdef MEM_PORT_ARB_PERF_EN
    .perf_if_grants (perf_if_grants),
    .perf_dm_grants (perf_dm_grants),
    .perf_conflicts (perf_conflicts),
`endif
    .bus (bus)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] init_val(input int i);
    return 32'hA5000000 ^ (32'(i) * 32'h00010101);
  endfunction
  // memory device: one-cycle read latency, write in the grant cycle
  logic [31:0] mem [256];
  logic        init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      init_done <= 1'b1;
    end else if (bus.mem_wen) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr[7:0]];
  end
  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", n, cyc, act, exp);
    end
  endfunction
  // reference model state
  logic [31:0] ref_mem [256];
  int          starve = 0;
  int          m_if = 0, m_dm = 0, m_cf = 0;
  logic        g_if, g_dm;
  ent_t        if_q[$];
  ent_t        dm_q[$];
  task automatic step(input logic r, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] wd);
    logic [31:0] e_addr;
    @(posedge clk);
    #1;
    cyc++;
    rst = r;
    bus.if_req = ir;
    bus.if_addr = ia;
    bus.dm_req = dr;
    bus.dm_we = dw;
    bus.dm_addr = da;
    bus.dm_wdata = wd;
    #1;
    g_if = !r && ir && (!dr || starve == MAX_WAIT);
    g_dm = !r && dr && !g_if;
    e_addr = g_if ? ia : g_dm ? da : 32'd0;
    chk("if_gnt", 32'(bus.if_gnt), 32'(g_if));
    chk("dm_gnt", 32'(bus.dm_gnt), 32'(g_dm));
    chk("mem_addr", bus.mem_addr, e_addr);
    chk("mem_wen", 32'(bus.mem_wen), 32'(g_dm && dw));
    chk("mem_wdata", bus.mem_wdata, g_dm ? wd : 32'd0);
    if (g_if) if_q.push_back('{ref_mem[ia[7:0]], cyc + 1});
    if (g_dm && !dw) dm_q.push_back('{ref_mem[da[7:0]], cyc + 1});
    if (g_dm && dw) ref_mem[da[7:0]] = wd;
    if (r) starve = 0;
    else if (g_if) starve = 0;
    else if (ir) starve = (starve + 1 > MAX_WAIT) ? MAX_WAIT : starve + 1;
    if (r) begin
      m_if = 0; m_dm = 0; m_cf = 0;
    end else begin
      m_if += int'(g_if);
      m_dm += int'(g_dm);
      m_cf += int'(ir && dr);
    end
  endtask
  // monitor: pop the response due this cycle; a reset cycle discards it
  ent_t mi, md;
  logic ei, ed;
  always @(negedge clk) if (run) begin
    while (if_q.size() > 0 && if_q[0].due < cyc) void'(if_q.pop_front());
    while (dm_q.size() > 0 && dm_q[0].due < cyc) void'(dm_q.pop_front());
    ei = if_q.size() > 0 && if_q[0].due == cyc;
    ed = dm_q.size() > 0 && dm_q[0].due == cyc;
    mi = '{32'd0, 0};
    md = '{32'd0, 0};
    if (ei) mi = if_q.pop_front();
    if (ed) md = dm_q.pop_front();
    chk("if_rvalid", 32'(bus.if_rvalid), 32'(ei && !rst));
    chk("dm_rvalid", 32'(bus.dm_rvalid), 32'(ed && !rst));
    chk("if_rdata", bus.if_rdata, (ei && !rst) ? mi.d : 32'd0);
    chk("dm_rdata", bus.dm_rdata, (ed && !rst) ? md.d : 32'd0);
  end
  initial begin
    logic        r, ir, dr, dw, p_if, p_dm;
    logic [31:0] ia, da, wd;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
    run = 1'b1;
    repeat (2) step(1, 1, 32'h7, 1, 0, 32'h3, 0);
    step(0, 0, 0, 1, 0, 32'h3, 0);
    repeat (3) step(0, 1, 32'h5, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 32'h7, 1, 0, 32'(i), 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 32'h10, 32'hDEAD);
    step(0, 0, 0, 1, 0, 32'h10, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h5, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    p_if = 0; p_dm = 0; ia = 0; da = 0; wd = 0; dw = 0;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 59) == 0;
      if (p_if) ir = $urandom_range(0, 9) != 0;
      else begin
        ir = $urandom_range(0, 2) != 0;
        ia = 32'($urandom_range(0, 15));
      end
      if (p_dm) dr = $urandom_range(0, 9) != 0;
      else begin
        dr = $urandom_range(0, 2) != 0;
        dw = $urandom_range(0, 2) == 0;
        da = 32'($urandom_range(0, 15));
        wd = $urandom;
      end
      step(r, ir, ia, dr, dw, da, wd);
      p_if = ir && !g_if;
      p_dm = dr && !g_dm;
    end
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
`ifdef MEM_PORT_ARB_PERF_EN
    chk("perf_if_grants", perf_if_grants, 32'(m_if));
    chk("perf_dm_grants", perf_dm_grants, 32'(m_dm));
    chk("perf_conflicts", perf_conflicts, 32'(m_cf));
`endif
    @(negedge clk);
    #1;
    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
